phase_sequencer: RTL

- Timed controller that generates the 3-bit one-hot `current_state` consumed by the ready/set/go decoder.
- Steps IDLE -> READY -> SET -> GO on a start request. READY and SET each last a fixed number of cycles. GO waits for a finish handshake or a timeout.
- Sits between the top-level control/handshake logic and the decoder; it is the only driver of `current_state`.

---
 rtl/phase_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// ---------------------------------------------------------------------------
// phase_sequencer
//
// Timed controller that walks IDLE -> READY -> SET -> GO and drives the
// one-hot phase code consumed by the ready/set/go decoder. It is the only
// driver of current_state.
//
// Ports:
//   clk           in   system clock, all state changes on the rising edge
//   rst_n         in   synchronous active-low reset, highest priority
//   start         in   begin a sequence (sampled only in IDLE)
//   abort         in   return to IDLE from any state, no pulses
//   finish        in   consumer handshake that ends GO (sampled only in GO)
//   current_state out  one-hot phase: bit0 READY, bit1 SET, bit2 GO, 0 = IDLE
//   busy          out  high whenever current_state is non-zero
//   done          out  one-cycle pulse, GO ended by finish
//   timeout       out  one-cycle pulse, GO ended by the GO_TIMEOUT limit
//   phase_count   out  cycles elapsed in the current phase, 0 on entry
//
// Handshake semantics: start is a level request that is accepted on the
// first rising edge where the sequencer is IDLE and abort is low; while
// busy it is simply not looked at. finish is accepted on any rising edge
// in GO (it wins over a coincident timeout, loses to abort). Acceptance of
// finish or expiry of GO is reported one cycle later as done or timeout,
// in the same cycle that current_state reads IDLE again, so a start held
// during that pulse cycle launches the next sequence immediately.
//
// Priority on every edge: rst_n > abort > finish (GO) > counter expiry >
// start (IDLE).
// ---------------------------------------------------------------------------
module phase_sequencer #(
    parameter int READY_CYCLES = 4,
    parameter int SET_CYCLES   = 2,
    parameter int GO_TIMEOUT   = 16,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             finish,
    output logic [2:0]       current_state,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] phase_count
);

    // Phase encodings; the register itself is the one-hot code, so the
    // FSM state is directly visible on current_state.
    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_READY = 3'b001;
    localparam logic [2:0] ST_SET   = 3'b010;
    localparam logic [2:0] ST_GO    = 3'b100;

    // Last count value of each phase. A limit of 2^CNT_W still fits because
    // only limit-1 is ever stored, so the counter never wraps.
    localparam logic [CNT_W-1:0] READY_LAST = CNT_W'(READY_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST   = CNT_W'(SET_CYCLES - 1);
    localparam logic [CNT_W-1:0] GO_LAST    = CNT_W'(GO_TIMEOUT - 1);

    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             done_q;
    logic             done_d;
    logic             timeout_q;
    logic             timeout_d;

    logic [CNT_W-1:0] phase_last;
    logic             phase_expired;

    // Limit of the phase currently held. IDLE uses 0 so that the compare
    // below is harmless there (IDLE never consults it).
    always_comb begin
        phase_last = '0;
        case (state_q)
            ST_READY: phase_last = READY_LAST;
            ST_SET:   phase_last = SET_LAST;
            ST_GO:    phase_last = GO_LAST;
            default:  phase_last = '0;
        endcase
    end

    assign phase_expired = (count_q == phase_last);

    // Next-state and pulse generation.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        done_d    = 1'b0;
        timeout_d = 1'b0;

        if (abort) begin
            // Abort is silent: no done/timeout, even if finish or expiry
            // coincide with it.
            state_d = ST_IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_d = '0;
                    if (start) begin
                        state_d = ST_READY;
                    end
                end

                ST_READY: begin
                    if (phase_expired) begin
                        state_d = ST_SET;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end

                ST_SET: begin
                    if (phase_expired) begin
                        state_d = ST_GO;
                        count_d = '0;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end

                ST_GO: begin
                    if (finish) begin
                        // finish is checked first so it wins on the
                        // expiry cycle.
                        state_d = ST_IDLE;
                        count_d = '0;
                        done_d  = 1'b1;
                    end else if (phase_expired) begin
                        state_d   = ST_IDLE;
                        count_d   = '0;
                        timeout_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end

                default: begin
                    // Unreachable encodings fall back to IDLE so the
                    // one-hot-or-zero property is restored in one cycle.
                    state_d = ST_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
        end
    end

    assign current_state = state_q;
    assign busy          = |state_q;
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign phase_count   = count_q;

endmodule
